// File: rtl/iob_boot_ctr_mc.sv
// Multi-core boot/reset controller on the IOb native bus.
// Optional watchdog: define IOB_BOOT_CTR_MC_WDT_EN.
module iob_boot_ctr_mc #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int N_CORES   = 2,
    parameter int PULSE_W   = 16,
    parameter int DEF_PULSE = 100
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_ready_o,
    output logic [N_CORES-1:0]  boot_o,
    output logic [N_CORES-1:0]  cpu_reset_o
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PULSE = 1'b1
    } state_e;

    localparam logic [PULSE_W-1:0] PULSE_ONE = PULSE_W'(1);
    localparam logic [PULSE_W-1:0] PULSE_DEF = PULSE_W'(DEF_PULSE);

    logic [2:0] off;
    logic       wr_en;
    logic       rd_en;

    assign off   = iob_addr_i[4:2];
    assign wr_en = iob_avalid_i & (|iob_wstrb_i);
    assign rd_en = iob_avalid_i & ~(|iob_wstrb_i);

    logic [N_CORES-1:0] boot_nxt_q, boot_nxt_d;
    logic [N_CORES-1:0] boot_q, boot_d;
    logic [PULSE_W-1:0] plen_q, plen_d;
    state_e             state_q [N_CORES];
    state_e             state_d [N_CORES];
    logic [PULSE_W-1:0] cnt_q [N_CORES];
    logic [PULSE_W-1:0] cnt_d [N_CORES];
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  rd_val;
    logic [N_CORES-1:0] req;
    logic               wdt_fire;
    logic               wdt_fired;
    logic [DATA_W-1:0]  wdt_rd;
    logic               unused_ok;

    assign unused_ok = ^{iob_addr_i[1:0], iob_wdata_i};

`ifdef IOB_BOOT_CTR_MC_WDT_EN
    logic [DATA_W-1:0] wdt_to_q;
    logic [DATA_W-1:0] wdt_cnt_q;
    logic              wdt_fired_q;

    assign wdt_fire  = (wdt_cnt_q == DATA_W'(1));
    assign wdt_fired = wdt_fired_q;
    assign wdt_rd    = wdt_to_q;

    // Expiry reloads from the timeout so the watchdog keeps re-arming
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdt_to_q    <= '0;
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else if (cke_i) begin
            if (wr_en && off == 3'd3) begin
                wdt_to_q  <= iob_wdata_i;
                wdt_cnt_q <= iob_wdata_i;
            end else if (wdt_cnt_q != '0) begin
                wdt_cnt_q <= wdt_fire ? wdt_to_q : wdt_cnt_q - DATA_W'(1);
            end
            if (wdt_fire)
                wdt_fired_q <= 1'b1;
            else if (wr_en && off == 3'd4)
                wdt_fired_q <= 1'b0;
        end
    end
`else
    assign wdt_fire  = 1'b0;
    assign wdt_fired = 1'b0;
    assign wdt_rd    = '0;
`endif

    always_comb begin
        req = '0;
        if (wr_en && off == 3'd1)
            req = iob_wdata_i[N_CORES-1:0];
        req = req | {N_CORES{wdt_fire}};
    end

    always_comb begin
        boot_nxt_d = boot_nxt_q;
        plen_d     = plen_q;
        if (wr_en && off == 3'd0)
            boot_nxt_d = iob_wdata_i[N_CORES-1:0];
        if (wr_en && off == 3'd2) begin
            if (iob_wdata_i[PULSE_W-1:0] == '0)
                plen_d = PULSE_ONE;
            else
                plen_d = iob_wdata_i[PULSE_W-1:0];
        end
    end

    // Per-core next state; a request in PULSE reloads and re-latches boot
    always_comb begin
        boot_d = boot_q;
        for (int k = 0; k < N_CORES; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (req[k]) begin
                state_d[k] = ST_PULSE;
                cnt_d[k]   = plen_q;
                boot_d[k]  = boot_nxt_q[k];
            end else if (state_q[k] == ST_PULSE) begin
                if (cnt_q[k] == PULSE_ONE)
                    state_d[k] = ST_RUN;
                else
                    cnt_d[k] = cnt_q[k] - PULSE_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            boot_nxt_q <= '1;
            boot_q     <= '1;
            plen_q     <= PULSE_DEF;
            for (int k = 0; k < N_CORES; k++) begin
                state_q[k] <= ST_PULSE;
                cnt_q[k]   <= PULSE_DEF;
            end
        end else if (cke_i) begin
            boot_nxt_q <= boot_nxt_d;
            boot_q     <= boot_d;
            plen_q     <= plen_d;
            for (int k = 0; k < N_CORES; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_CORES; k++)
            cpu_reset_o[k] = (state_q[k] == ST_PULSE);
    end

    assign boot_o = boot_q;

    always_comb begin
        rd_val = '0;
        case (off)
            3'd0: rd_val[N_CORES-1:0] = boot_nxt_q;
            3'd1: rd_val[N_CORES-1:0] = cpu_reset_o;
            3'd2: rd_val[PULSE_W-1:0] = plen_q;
            3'd3: rd_val              = wdt_rd;
            3'd4: begin
                rd_val[N_CORES-1:0] = cpu_reset_o;
                rd_val[16]          = wdt_fired;
            end
            default: rd_val = '0;
        endcase
    end

    assign rdata_d = rd_en ? rd_val : rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cke_i) begin
            rvalid_q <= rd_en;
            rdata_q  <= rdata_d;
        end
    end

    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;
    assign iob_ready_o  = 1'b1;

endmodule

// File: tb/tb_iob_boot_ctr_mc.sv
// Directed bench for iob_boot_ctr_mc (default parameters).
// Watchdog checks follow IOB_BOOT_CTR_MC_WDT_EN.
module tb_iob_boot_ctr_mc;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cke_i;
    logic        avalid;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic [1:0]  boot;
    logic [1:0]  cpu_reset;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iob_boot_ctr_mc dut (
        .clk_i        (clk),
        .cke_i        (cke_i),
        .rst_i        (rst_i),
        .iob_avalid_i (avalid),
        .iob_addr_i   (addr),
        .iob_wdata_i  (wdata),
        .iob_wstrb_i  (wstrb),
        .iob_rvalid_o (rvalid),
        .iob_rdata_o  (rdata),
        .iob_ready_o  (ready),
        .boot_o       (boot),
        .cpu_reset_o  (cpu_reset)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; accepted at the next posedge
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avalid = 1'b1;
        addr   = a;
        wdata  = d;
        wstrb  = 4'hf;
        @(negedge clk);
        avalid = 1'b0;
        wstrb  = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
        avalid = 1'b1;
        addr   = a;
        wstrb  = 4'h0;
        @(negedge clk);
        avalid = 1'b0;
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk(tag, rdata, exp);
    endtask

    task automatic measure(input int k, output int len);
        len = 0;
        while (cpu_reset[k] && len < 1000) begin
            len++;
            @(negedge clk);
        end
    endtask

    int n;
    int m;
    logic [31:0] held;

    initial begin
        rst_i  = 1'b1;
        cke_i  = 1'b1;
        avalid = 1'b0;
        addr   = '0;
        wdata  = '0;
        wstrb  = '0;
        repeat (3) @(negedge clk);

        chk("rst_cpu_reset", 32'(cpu_reset), 32'h3);
        chk("rst_boot", 32'(boot), 32'h3);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", 32'(ready), 32'h1);

        // Power-up pulse
        rst_i = 1'b0;
        measure(0, n);
        chk("pwrup_len", n, 100);
        chk("pwrup_after", 32'(cpu_reset), 32'h0);
        chk("pwrup_boot", 32'(boot), 32'h3);

        // Boot switch on core 0 only
        wr(5'h00, 32'h0);
        wr(5'h04, 32'h1);
        chk("bsw_boot", 32'(boot), 32'h2);
        chk("bsw_reset", 32'(cpu_reset), 32'h1);
        measure(0, n);
        chk("bsw_len", n, 100);
        rd("rd_boot", 5'h00, 32'h0);
        @(negedge clk);
        chk("rd_rvalid_drop", 32'(rvalid), 32'h0);
        chk("rd_rdata_hold", rdata, 32'h0);

        // Programmable pulse length
        wr(5'h08, 32'd5);
        wr(5'h04, 32'h3);
        chk("plen_reset", 32'(cpu_reset), 32'h3);
        chk("plen_boot", 32'(boot), 32'h0);
        measure(0, n);
        chk("plen_len", n, 5);
        chk("plen_both_off", 32'(cpu_reset), 32'h0);
        wr(5'h08, 32'd0);
        rd("plen_zero", 5'h08, 32'h1);

        // Pulse extension on core 1
        wr(5'h08, 32'd10);
        wr(5'h04, 32'h2);
        @(negedge clk);
        chk("ext_mid", 32'(cpu_reset), 32'h2);
        @(negedge clk);
        wr(5'h04, 32'h2);
        measure(1, n);
        chk("ext_len", n + 3, 13);

        // Unmapped offset
        rd("rd_off5", 5'h14, 32'h0);

        // Clock-enable freeze mid-pulse
        wr(5'h04, 32'h1);
        n = 0;
        repeat (3) begin
            if (cpu_reset[0]) n++;
            @(negedge clk);
        end
        cke_i = 1'b0;
        held  = rdata;
        repeat (20) begin
            if (cpu_reset[0]) n++;
            @(negedge clk);
        end
        chk("cke_rdata_hold", rdata, held);
        cke_i = 1'b1;
        measure(0, m);
        chk("cke_len", n + m, 30);

`ifdef IOB_BOOT_CTR_MC_WDT_EN
        wr(5'h0c, 32'd50);
        n = 1;
        while (cpu_reset == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wdt_fire_cycle", n, 51);
        chk("wdt_reset", 32'(cpu_reset), 32'h3);
        rd("wdt_status", 5'h10, 32'h0001_0003);
        wr(5'h10, 32'h0);
        rd("wdt_status_clr", 5'h10, 32'h0000_0003);
        wr(5'h0c, 32'd0);
`else
        wr(5'h0c, 32'd50);
        rd("wdt_off_rd", 5'h0c, 32'h0);
        repeat (60) @(negedge clk);
        chk("wdt_off_reset", 32'(cpu_reset), 32'h0);
        rd("wdt_off_status", 5'h10, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
